// File: rtl/util_keypad_scan.sv
// 4x4 matrix keypad scanner: one active-low row at a time, synchronised
// column sampling, frame-level debounce with press/release pulse vectors.
module util_keypad_scan #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        enable,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  output logic [15:0] keys,
  output logic [15:0] key_pressed,
  output logic [15:0] key_released,
  output logic        any_key,
  output logic        scan_done
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EVAL
  } state_t;

  state_t        state;
  logic [1:0]    row;
  logic [SW-1:0] settle;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [15:0]   frame;
  logic [15:0]   prev_frame;
  logic [3:0]    stable;
  logic [3:0]    stable_next;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1 <= 4'hF;
      sync2 <= 4'hF;
    end else begin
      sync1 <= col_n;
      sync2 <= sync1;
    end
  end

  // saturating run length of identical frames
  always_comb begin
    stable_next = 4'd1;
    if (frame == prev_frame)
      stable_next = (stable >= DEB) ? DEB : stable + 4'd1;
  end

  assign any_key = |keys;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state        <= IDLE;
      row          <= 2'd0;
      settle       <= '0;
      row_n        <= 4'hF;
      frame        <= 16'h0;
      prev_frame   <= 16'h0;
      stable       <= 4'd0;
      keys         <= 16'h0;
      key_pressed  <= 16'h0;
      key_released <= 16'h0;
      scan_done    <= 1'b0;
    end else begin
      scan_done    <= 1'b0;
      key_pressed  <= 16'h0;
      key_released <= 16'h0;
      unique case (state)
        IDLE: begin
          row_n <= 4'hF;
          if (enable) begin
            state  <= SCAN;
            row    <= 2'd0;
            settle <= '0;
            row_n  <= 4'hE;
          end
        end
        SCAN: begin
          if (!enable) begin
            state <= IDLE;
            row_n <= 4'hF;
          end else if (settle == SETTLE_LAST) begin
            frame[{row, 2'b00} +: 4] <= ~sync2;
            settle <= '0;
            if (row == 2'd3) begin
              state <= EVAL;
              row_n <= 4'hF;
            end else begin
              row   <= row + 2'd1;
              row_n <= ~(4'b0001 << (row + 2'd1));
            end
          end else begin
            settle <= settle + 1'b1;
          end
        end
        EVAL: begin
          stable     <= stable_next;
          prev_frame <= frame;
          scan_done  <= 1'b1;
          if (stable_next >= DEB && frame != keys) begin
            keys         <= frame;
            key_pressed  <= frame & ~keys;
            key_released <= keys & ~frame;
          end
          if (enable) begin
            state  <= SCAN;
            row    <= 2'd0;
            settle <= '0;
            row_n  <= 4'hE;
          end else begin
            state <= IDLE;
            row_n <= 4'hF;
          end
        end
        default: begin
          state <= IDLE;
          row_n <= 4'hF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_util_keypad_scan.sv
// Bench for util_keypad_scan: ideal keypad matrix model driving col_n,
// frame-history debounce reference, directed plus random key patterns.
module tb_util_keypad_scan;

  localparam int D = 3;
  localparam int PERIOD = 17;

  logic        clk;
  logic        res;
  logic        enable;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic [15:0] keys;
  logic [15:0] key_pressed;
  logic [15:0] key_released;
  logic        any_key;
  logic        scan_done;

  util_keypad_scan dut (
    .clk          (clk),
    .res          (res),
    .enable       (enable),
    .col_n        (col_n),
    .row_n        (row_n),
    .keys         (keys),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .any_key      (any_key),
    .scan_done    (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // physical keypad: held keys pull their column low when their row is driven
  logic [15:0] pressed;
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r*4+c])
          col_n[c] = 1'b0;
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference: keys follow a frame once the last D frames were identical
  logic [15:0] hist[$];
  logic [15:0] mkeys;
  logic [15:0] cur;
  int          last_cyc;
  bit          first;

  task automatic model_frame(input logic [15:0] f,
                             output logic [15:0] ep,
                             output logic [15:0] er);
    bit same;
    hist.push_back(f);
    if (hist.size() > D) void'(hist.pop_front());
    same = (hist.size() == D);
    foreach (hist[i]) if (hist[i] != f) same = 0;
    ep = 16'h0;
    er = 16'h0;
    if (same && f != mkeys) begin
      ep = f & ~mkeys;
      er = mkeys & ~f;
      mkeys = f;
    end
  endtask

  task automatic step(input logic [15:0] next);
    int n;
    bit seen;
    logic [15:0] ep;
    logic [15:0] er;
    n = 0;
    seen = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (scan_done) seen = 1;
      else chk("quiet", {key_pressed, key_released}, 32'h0);
    end
    if (!seen) begin
      chk("timeout", 32'(seen), 32'h1);
    end else begin
      if (!first) chk("period", 32'(cyc - last_cyc), 32'(PERIOD));
      last_cyc = cyc;
      first = 0;
      model_frame(cur, ep, er);
      chk("keys", {16'h0, keys}, {16'h0, mkeys});
      chk("pressed", {16'h0, key_pressed}, {16'h0, ep});
      chk("released", {16'h0, key_released}, {16'h0, er});
      chk("any_key", {31'h0, any_key}, {31'h0, |mkeys});
    end
    cur = next;
    pressed = next;
    @(negedge clk);
    chk("pulse_clear", {15'h0, scan_done, key_pressed},
        {15'h0, 1'b0, 16'h0});
    chk("rel_clear", {16'h0, key_released}, 32'h0);
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n;
    n = 0;
    while (row_n !== r && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("wait_row", {28'h0, row_n}, {28'h0, r});
  endtask

  logic [15:0] seq[] = '{
    16'h0020, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h8000, 16'h8000,
    16'h0001, 16'h0001, 16'h0001, 16'h0001,
    16'h0012, 16'h0012, 16'h0012, 16'h0012
  };

  initial begin
    logic [3:0]  exp_row;
    logic [15:0] held;
    vectors = 0;
    errors = 0;
    cyc = 0;
    last_cyc = 0;
    first = 1;
    mkeys = 16'h0;
    cur = 16'h0;
    pressed = 16'h0;
    enable = 1'b0;
    res = 1'b0;
    #2 res = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_row", {28'h0, row_n}, 32'hF);
    chk("rst_keys", {16'h0, keys}, 32'h0);
    chk("rst_pulses", {key_pressed, key_released}, 32'h0);
    chk("rst_flags", {30'h0, any_key, scan_done}, 32'h0);
    res = 1'b0;
    enable = 1'b1;

    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      exp_row = i < 4 ? 4'hE : i < 8 ? 4'hD : i < 12 ? 4'hB :
                i < 16 ? 4'h7 : 4'hF;
      chk("row_seq", {28'h0, row_n}, {28'h0, exp_row});
    end
    step(16'h0020);
    foreach (seq[i]) step(seq[i]);

    // drop enable while row 2 is driven
    wait_row(4'hB);
    held = keys;
    enable = 1'b0;
    @(negedge clk);
    chk("dis_row", {28'h0, row_n}, 32'hF);
    repeat (25) begin
      @(negedge clk);
      chk("dis_idle", {11'h0, scan_done, row_n, keys},
          {11'h0, 1'b0, 4'hF, held});
    end
    enable = 1'b1;
    @(negedge clk);
    chk("reen_row", {28'h0, row_n}, 32'hE);
    first = 1;
    step(16'h0020);
    step(16'h0020);
    step(16'h0020);
    step(16'h0020);
    step(16'h0020);
    chk("key5_held", {16'h0, keys}, 32'h0020);

    // reset in the middle of a scan
    wait_row(4'hD);
    res = 1'b1;
    #1;
    chk("mid_rst_row", {28'h0, row_n}, 32'hF);
    chk("mid_rst_keys", {16'h0, keys}, 32'h0);
    chk("mid_rst_pulse", {key_pressed, key_released}, 32'h0);
    chk("mid_rst_flags", {30'h0, any_key, scan_done}, 32'h0);
    @(negedge clk);
    res = 1'b0;
    hist.delete();
    mkeys = 16'h0;
    first = 1;
    repeat (4) step(16'h0020);
    chk("after_rst", {16'h0, keys}, 32'h0020);

    repeat (24) begin
      if ($urandom_range(0, 2) == 0)
        step(16'($urandom_range(0, 65535)));
      else
        step(cur);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/util_keypad_scan.md
Name: util_keypad_scan

Overview:
- Scan controller for a 4x4 matrix keypad (16 hex keys) on the core's input path.
- Drives one row low at a time and samples the column lines through a two-flop synchroniser.
- Debounces whole-matrix frames and publishes a stable 16-bit key state plus one-cycle press and release pulse vectors to the CPU input logic.

Parameters:
- SETTLE_CYCLES, default 4: cycles each row is driven before its columns are sampled. Legal minimum is 3 (synchroniser latency plus one).
- DEBOUNCE_SCANS, default 3: number of consecutive identical frames needed before keys updates. Legal range is 1..15.

Ports:
- clk  in  1  system clock
- res  in  1  asynchronous active-high reset
- enable  in  1  scanning allowed
- col_n  in  4  raw column inputs; asynchronous, active-low, externally pulled up
- row_n  out  4  row drives, active-low; at most one bit low
- keys  out  16  debounced key state; bit index = row*4 + col; 1 = pressed
- key_pressed  out  16  one-cycle pulse per key newly pressed
- key_released  out  16  one-cycle pulse per key newly released
- any_key  out  1  OR of keys
- scan_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (asynchronous, res high):
  - row_n=4'hF; keys, key_pressed, key_released, frame and prev_frame all 0; any_key=0; scan_done=0.
  - Synchroniser flops = 4'hF; stable counter=0; FSM=IDLE.
- Synchroniser: col_s = col_n delayed 2 clk. Sample value for column c = !col_s[c].
- FSM states:
  - IDLE: row_n=4'hF. If enable, go to SCAN with row=0, settle counter=0.
  - SCAN: row_n has bit[row]=0 and all other bits 1. The settle counter increments each cycle. When it equals SETTLE_CYCLES-1, latch frame[row*4+3:row*4] from the sampled columns and clear the counter. For row<3, increment row; for row=3, go to EVAL.
  - EVAL: one cycle, row_n=4'hF.
    - Debounce update: if frame==prev_frame, stable counter increments, saturating at DEBOUNCE_SCANS; otherwise it is set to 1.
    - prev_frame <= frame.
    - If the new counter value is ≥ DEBOUNCE_SCANS and frame != keys: keys <= frame, key_pressed <= frame & ~keys, key_released <= keys & ~frame. Otherwise both pulse vectors are 0.
    - Next state: SCAN at row 0 if enable, else IDLE.
- Frame period is 4*SETTLE_CYCLES+1 cycles; default is 17.
- Output timing:
  - scan_done, keys, key_pressed and key_released all change on the clock edge ending EVAL, so they are visible together in the following cycle.
  - scan_done and the pulse vectors return to 0 one cycle later.
  - any_key is combinational from keys.
- Debounce boundaries:
  - DEBOUNCE_SCANS=1 updates keys on every frame that differs from keys.
  - A bounce in any frame restarts the count at 1.
  - Multiple simultaneous key changes are reported in the same pulse cycle.
- enable deasserted during SCAN:
  - The next state is IDLE and row_n=4'hF from the next cycle.
  - The partial frame is discarded: the frame register keeps old bits, and the next scan overwrites every row before EVAL.
  - keys, prev_frame and the stable counter hold their values.
- enable deasserted in EVAL: EVAL completes normally, then the FSM goes to IDLE.
- Reset mid-frame: immediate return to reset values, with no pulses emitted.
- Ghosting and multi-key masking in the matrix are not corrected; raw samples are taken as-is.

Test Plan:
- Reset release, enable=1, no keys:
  - row_n cycles E,D,B,7 with each value held 4 cycles, then F for 1 cycle.
  - scan_done pulses every 17 cycles; keys stays 0.
- Hold key 5 (row1/col1: col_n[1]=0 while row_n[1]=0), default parameters:
  - keys becomes 16'h0020 on the third scan_done.
  - key_pressed=16'h0020 for exactly 1 cycle; any_key=1.
  - Release the key: after 3 frames key_released=16'h0020 and keys=0.
- Bounce:
  - Key F (row3/col3) present in frames 1 and 2, absent in frame 3, present in frames 4-6 -> keys=16'h8000 only after frame 6.
  - No pulse occurs before frame 6.
- Simultaneous change: keys=16'h0001, then pattern switches to key 0 released and keys 1 and 4 pressed -> one cycle with key_pressed=16'h0012, key_released=16'h0001, keys=16'h0012.
- Drop enable mid-row 2 -> row_n=F from the next cycle, no scan_done, keys unchanged; re-enable restarts at row 0.
- Assert res mid-SCAN with keys=16'h0020 -> row_n=F, keys=0 and no pulses in the same cycle; scanning resumes after res deasserts.
